axi4_lite_reg_bank: RTL and testbench

Parametrised AXI4-Lite slave register bank. It is the standard DUT for the team's UVM register-model benches and is sized by the same AXI4-Lite address and data widths used in the verification parameter package. It exposes NUM_REGS word registers to fabric logic, each configured per register as read-write or hardware-driven read-only. It adds per-byte write strobes, SLVERR signalling and per-register write pulses.

---
 rtl/axi4_lite_reg_bank_pkg.sv | 36 +++
 rtl/axi4_lite_strb_merge.sv | 22 ++
 rtl/axi4_lite_reg_bank.sv | 199 +++++++++++++++++++
 tb/tb_axi4_lite_reg_bank.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank: response codes,
// channel FSM states and byte-address decode.
package axi4_lite_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_BOTH,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] index;
  } reg_decode_t;

  // Word index is the byte address with the in-word byte offset dropped.
  function automatic reg_decode_t decode_addr(input logic [63:0] addr,
                                              input int addr_lsb,
                                              input int num_regs);
    reg_decode_t d;
    logic [63:0] idx;
    idx     = addr >> addr_lsb;
    d.valid = (idx < 64'(num_regs));
    d.index = idx[31:0];
    return d;
  endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge of write data into an existing register word under wstrb.
module axi4_lite_strb_merge
  import axi4_lite_reg_bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   new_word
);

  logic [DATA_W-1:0] mask;

  genvar gi;
  for (gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
    assign mask[gi*8 +: 8] = {8{wstrb[gi]}};
  end

  assign new_word = (old_word & ~mask) | (wdata & mask);

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS word registers, each either read-write or
// a read-only mirror of fabric inputs, with per-register write pulses.
module axi4_lite_reg_bank
  import axi4_lite_reg_bank_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] RST_VALS = '0
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]    i_awaddr,
  input  logic                                   i_awvalid,
  output logic                                   o_awready,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]    i_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]  i_wstrb,
  input  logic                                   i_wvalid,
  output logic                                   o_wready,
  output logic [1:0]                             o_bresp,
  output logic                                   o_bvalid,
  input  logic                                   i_bready,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]    i_araddr,
  input  logic                                   i_arvalid,
  output logic                                   o_arready,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]    o_rdata,
  output logic [1:0]                             o_rresp,
  output logic                                   o_rvalid,
  input  logic                                   i_rready,
  input  logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_vals,
  output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_reg_vals,
  output logic [NUM_REGS-1:0]                    o_wr_pulse
);

  localparam int AW       = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW       = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;

  logic              aw_held_reg, w_held_reg;
  logic [AW-1:0]     awaddr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [SW-1:0]     wstrb_reg;
  logic [1:0]        bresp_reg;
  logic [NUM_REGS-1:0] wr_pulse_reg;
  logic [DW-1:0]     rdata_reg;
  logic [1:0]        rresp_reg;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_ok;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [SW-1:0]     wr_strb;
  reg_decode_t       wr_dec, rd_dec;
  logic [NUM_REGS-1:0] wr_onehot, rd_onehot;
  logic [DW-1:0]     cur_vals [NUM_REGS];
  logic [DW-1:0]     rd_word;

  // Readies come only from registered state, never from incoming valids.
  assign o_awready = (wr_state_reg != W_RESP) && !aw_held_reg;
  assign o_wready  = (wr_state_reg != W_RESP) && !w_held_reg;
  assign o_bvalid  = (wr_state_reg == W_RESP);
  assign o_arready = (rd_state_reg == R_IDLE);
  assign o_rvalid  = (rd_state_reg == R_RESP);

  assign aw_hs  = i_awvalid && o_awready;
  assign w_hs   = i_wvalid && o_wready;
  assign b_hs   = o_bvalid && i_bready;
  assign ar_hs  = i_arvalid && o_arready;
  assign r_hs   = o_rvalid && i_rready;
  assign commit = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

  // A handshake in the commit cycle supplies its payload directly.
  assign wr_addr = aw_hs ? i_awaddr : awaddr_reg;
  assign wr_data = w_hs ? i_wdata : wdata_reg;
  assign wr_strb = w_hs ? i_wstrb : wstrb_reg;

  assign wr_dec = decode_addr(64'(wr_addr), ADDR_LSB, NUM_REGS);
  assign rd_dec = decode_addr(64'(i_araddr), ADDR_LSB, NUM_REGS);
  assign wr_ok  = wr_dec.valid && !(|(wr_onehot & RO_MASK));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state_reg <= W_IDLE;
      rd_state_reg <= R_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:      if (commit) wr_state_next = W_RESP;
                   else if (aw_hs || w_hs) wr_state_next = W_WAIT_BOTH;
      W_WAIT_BOTH: if (commit) wr_state_next = W_RESP;
      W_RESP:      if (b_hs) wr_state_next = W_IDLE;
      default:     wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (ar_hs) rd_state_next = R_RESP;
      R_RESP:  if (r_hs) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      bresp_reg    <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          awaddr_reg  <= i_awaddr;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          wdata_reg  <= i_wdata;
          wstrb_reg  <= i_wstrb;
        end
      end
      wr_pulse_reg <= (commit && wr_ok) ? wr_onehot : '0;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign wr_onehot[gi] = wr_dec.valid && (wr_dec.index == 32'(gi));
    assign rd_onehot[gi] = rd_dec.valid && (rd_dec.index == 32'(gi));

    if (RO_MASK[gi]) begin : g_ro
      assign cur_vals[gi] = i_ro_vals[gi*DW +: DW];
    end else begin : g_rw
      logic [DW-1:0] value_reg;
      logic [DW-1:0] value_next;
      logic          unused_ro_slice;

      assign unused_ro_slice = ^i_ro_vals[gi*DW +: DW];

      axi4_lite_strb_merge #(.DATA_W(DW)) u_merge (
        .old_word (value_reg),
        .wdata    (wr_data),
        .wstrb    (wr_strb),
        .new_word (value_next)
      );

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) value_reg <= RST_VALS[gi*DW +: DW];
        else if (commit && wr_ok && wr_onehot[gi]) value_reg <= value_next;
      end

      assign cur_vals[gi] = value_reg;
    end

    assign o_reg_vals[gi*DW +: DW] = cur_vals[gi];
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_onehot[k]) rd_word = cur_vals[k];
    end
  end

  // Read data is captured at the AR handshake, before any same-cycle commit lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_word;
      rresp_reg <= rd_dec.valid ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign o_bresp    = bresp_reg;
  assign o_rdata    = rdata_reg;
  assign o_rresp    = rresp_reg;
  assign o_wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed self-checking bench for axi4_lite_reg_bank with register 2 read-only.
module tb_axi4_lite_reg_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] ro_vals, reg_vals;
  logic [7:0]   wr_pulse;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi4_lite_reg_bank #(
    .AXI4_LITE_ADDR_BIT_WIDTH (32),
    .AXI4_LITE_DATA_BIT_WIDTH (32),
    .NUM_REGS                 (8),
    .RO_MASK                  (8'h04),
    .RST_VALS                 ('0)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_awaddr  (awaddr),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .o_bresp   (bresp),
    .o_bvalid  (bvalid),
    .i_bready  (bready),
    .i_araddr  (araddr),
    .i_arvalid (arvalid),
    .o_arready (arready),
    .o_rdata   (rdata),
    .o_rresp   (rresp),
    .o_rvalid  (rvalid),
    .i_rready  (rready),
    .i_ro_vals (ro_vals),
    .o_reg_vals(reg_vals),
    .o_wr_pulse(wr_pulse)
  );

  // Drives a same-cycle AW+W write and collects the response and pulse activity.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic got_b,
                          output logic [1:0] resp, output logic [7:0] pulse_or,
                          output int pulse_cycles);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    pulse_or = '0; pulse_cycles = 0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    got_b = bvalid; resp = bresp;
    for (int i = 0; i < 3; i++) begin
      if (wr_pulse != 8'h00) pulse_cycles++;
      pulse_or |= wr_pulse;
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic got_r,
                         output logic [31:0] data, output logic [1:0] resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    got_r = rvalid; data = rdata; resp = rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic g; logic [31:0] d; logic [1:0] r; logic [31:0] exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++; $display("FAIL reset_ready got=%b want=111", {awready, wready, arready});
    end
    vectors++;
    if ({bvalid, rvalid, wr_pulse, bresp, rresp, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got bv=%b rv=%b pulse=%h bresp=%b rresp=%b rdata=%h want all 0",
               bvalid, rvalid, wr_pulse, bresp, rresp, rdata);
    end
    for (int k = 0; k < 8; k++) begin
      exp = (k == 2) ? 32'h12345678 : 32'h0;
      do_read(32'(k * 4), g, d, r);
      vectors++;
      if (g !== 1'b1 || d !== exp || r !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_read idx=%0d got rv=%b data=%h resp=%b want rv=1 data=%h resp=00",
                 k, g, d, r, exp);
      end
      $display("read idx=%0d data=%h resp=%b", k, d, r);
    end
  endtask

  task automatic test_strobes();
    logic g; logic [1:0] r; logic [7:0] p; int pc; logic [31:0] d;
    do_write(32'h04, 32'hDEADBEEF, 4'b1111, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b00 || p !== 8'h02 || pc != 1) begin
      miscompares++;
      $display("FAIL write_full got bv=%b resp=%b pulse=%h cycles=%0d want 1 00 02 1", g, r, p, pc);
    end
    do_write(32'h04, 32'h000000AA, 4'b0001, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b00 || p !== 8'h02 || pc != 1) begin
      miscompares++;
      $display("FAIL write_byte got bv=%b resp=%b pulse=%h cycles=%0d want 1 00 02 1", g, r, p, pc);
    end
    do_write(32'h05, 32'hFFFFFFFF, 4'b0000, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b00 || p !== 8'h02 || pc != 1) begin
      miscompares++;
      $display("FAIL write_nostrb got bv=%b resp=%b pulse=%h cycles=%0d want 1 00 02 1", g, r, p, pc);
    end
    do_read(32'h04, g, d, r);
    vectors++;
    if (d !== 32'hDEADBEAA || r !== 2'b00) begin
      miscompares++; $display("FAIL strobe_read got data=%h resp=%b want deadbeaa 00", d, r);
    end
    vectors++;
    if (reg_vals[32 +: 32] !== 32'hDEADBEAA) begin
      miscompares++; $display("FAIL strobe_regvals got=%h want=deadbeaa", reg_vals[32 +: 32]);
    end
    $display("strobe read 0x04 data=%h", d);
  endtask

  task automatic test_w_before_aw();
    int held = 0; int pc = 0;
    bready = 1'b0;
    awaddr = 32'h0C; wdata = 32'h01234567; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    vectors++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      miscompares++; $display("FAIL w_first_capture got wr=%b awr=%b bv=%b want 0 1 0", wready, awready, bvalid);
    end
    repeat (2) @(negedge clk);
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 8'h08 || awready !== 1'b0 || wready !== 1'b0) begin
      miscompares++;
      $display("FAIL w_first_commit got bv=%b resp=%b pulse=%h awr=%b wr=%b want 1 00 08 0 0",
               bvalid, bresp, wr_pulse, awready, wready);
    end
    vectors++;
    if (reg_vals[96 +: 32] !== 32'h01234567) begin
      miscompares++; $display("FAIL w_first_value got=%h want=01234567", reg_vals[96 +: 32]);
    end
    for (int i = 0; i < 5; i++) begin
      if (bvalid === 1'b1 && bresp === 2'b00) held++;
      if (wr_pulse != 8'h00) pc++;
      if (i == 4) bready = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (held != 5 || pc != 1) begin
      miscompares++; $display("FAIL b_backpressure got held=%0d pulses=%0d want 5 1", held, pc);
    end
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || wr_pulse !== 8'h00) begin
      miscompares++;
      $display("FAIL b_release got bv=%b awr=%b wr=%b pulse=%h want 0 1 1 00", bvalid, awready, wready, wr_pulse);
    end
    $display("w-before-aw write 0x0C held=%0d", held);
  endtask

  task automatic test_read_only();
    logic g; logic [1:0] r; logic [7:0] p; int pc; logic [31:0] d;
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b10 || p !== 8'h00) begin
      miscompares++; $display("FAIL ro_write got bv=%b resp=%b pulse=%h want 1 10 00", g, r, p);
    end
    do_read(32'h08, g, d, r);
    vectors++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      miscompares++; $display("FAIL ro_read got data=%h resp=%b want 12345678 00", d, r);
    end
    ro_vals[64 +: 32] = 32'h0BADF00D;
    do_read(32'h08, g, d, r);
    vectors++;
    if (d !== 32'h0BADF00D || reg_vals[64 +: 32] !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL ro_track got data=%h regvals=%h want 0badf00d", d, reg_vals[64 +: 32]);
    end
    $display("ro read 0x08 data=%h", d);
  endtask

  task automatic test_out_of_range();
    logic g; logic [1:0] r; logic [7:0] p; int pc; logic [31:0] d;
    logic [255:0] exp;
    exp = '0;
    exp[32 +: 32] = 32'hDEADBEAA;
    exp[64 +: 32] = 32'h0BADF00D;
    exp[96 +: 32] = 32'h01234567;
    do_read(32'h20, g, d, r);
    vectors++;
    if (g !== 1'b1 || d !== 32'h0 || r !== 2'b10) begin
      miscompares++; $display("FAIL oor_read got rv=%b data=%h resp=%b want 1 0 10", g, d, r);
    end
    do_write(32'h20, 32'hFFFFFFFF, 4'hF, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b10 || p !== 8'h00) begin
      miscompares++; $display("FAIL oor_write got bv=%b resp=%b pulse=%h want 1 10 00", g, r, p);
    end
    vectors++;
    if (reg_vals !== exp) begin
      miscompares++; $display("FAIL oor_regvals got=%h want=%h", reg_vals, exp);
    end
    $display("out-of-range 0x20 bresp=%b", r);
  endtask

  task automatic test_same_cycle_and_reset();
    logic g; logic [1:0] r; logic [7:0] p; int pc; logic [31:0] d; int stray = 0;
    do_write(32'h00, 32'h11, 4'hF, g, r, p, pc);
    awaddr = 32'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h00; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'h11 || bvalid !== 1'b1 || wr_pulse !== 8'h01) begin
      miscompares++;
      $display("FAIL same_cycle got rv=%b rdata=%h bv=%b pulse=%h want 1 00000011 1 01", rvalid, rdata, bvalid, wr_pulse);
    end
    @(negedge clk);
    do_read(32'h00, g, d, r);
    vectors++;
    if (d !== 32'h55) begin
      miscompares++; $display("FAIL after_same_cycle got=%h want=00000055", d);
    end
    awaddr = 32'h10; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      miscompares++; $display("FAIL aw_only_capture got awr=%b wr=%b want 0 1", awready, wready);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got awr=%b bv=%b want 1 0", awready, bvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid !== 1'b0) stray++;
      @(negedge clk);
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL reset_no_resp got bvalid cycles=%0d want 0", stray);
    end
    do_write(32'h10, 32'h77, 4'hF, g, r, p, pc);
    vectors++;
    if (g !== 1'b1 || r !== 2'b00 || p !== 8'h10 || pc != 1) begin
      miscompares++; $display("FAIL post_reset_write got bv=%b resp=%b pulse=%h cycles=%0d want 1 00 10 1", g, r, p, pc);
    end
    do_read(32'h10, g, d, r);
    vectors++;
    if (d !== 32'h77 || r !== 2'b00) begin
      miscompares++; $display("FAIL post_reset_read got data=%h resp=%b want 00000077 00", d, r);
    end
    $display("post-reset read 0x10 data=%h", d);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    ro_vals = {8{32'hA5A5A5A5}};
    ro_vals[64 +: 32] = 32'h12345678;
    test_reset();
    test_strobes();
    test_w_before_aw();
    test_read_only();
    test_out_of_range();
    test_same_cycle_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
